traffic_phase_ctrl: RTL and testbench
=====================================

Name: traffic_phase_ctrl

Overview:
Sequencing controller for a two-road intersection built from the team's traffic-light FSM light encoding. It owns the phase timing for the north-south (NS) and east-west (EW) signal heads. It also arbitrates the shared crossing between vehicle phases, a pedestrian request and an emergency override. The controller sits above the per-head light outputs and drives them directly, together with phase and timer status for debug and verification.

Parameters:
GREEN_CYC, 8, cycles per green phase (must be >= 1)
YELLOW_CYC, 3, cycles per yellow phase (>= 1)
ALLRED_CYC, 2, cycles per all-red clearance phase (>= 1)
WALK_CYC, 6, cycles per pedestrian walk phase (>= 1)
CNT_W, 8, timer width; every *_CYC value must be <= 2^CNT_W

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
ped_req  input  1  pedestrian request, level-sampled every clock
emerg  input  1  emergency override, level, synchronous sampling
ns_light  output  3  NS head {red,yellow,green}, one-hot
ew_light  output  3  EW head {red,yellow,green}, one-hot
walk  output  1  pedestrian walk lamp
ped_ack  output  1  one-cycle pulse on the first WALK cycle
state  output  3  current phase encoding
timer  output  CNT_W  remaining cycles in phase minus 1

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high (rst).
- Phase encoding: ALLRED=0, NS_GREEN=1, NS_YELLOW=2, EW_GREEN=3, EW_YELLOW=4, WALK=5, EMERG=6. Value 7 is illegal and recovers to ALLRED with timer=ALLRED_CYC-1.
- Outputs are decoded from registered state only. There is no combinational path from any input to any output.
  - ns_light: 001 in NS_GREEN, 010 in NS_YELLOW, else 100.
  - ew_light: same pattern for the EW phases.
  - walk: 1 only in WALK.
- Reset values: state=ALLRED, timer=ALLRED_CYC-1, next_dir=NS, ped_pend=0, ped_ack=0. Both heads show 100 and walk=0.
- Timer: loaded with DUR-1 on every phase entry, then decremented once per cycle. A phase exits on the edge where timer==0, so each phase lasts exactly DUR cycles. In EMERG the timer holds 0.
- Normal transitions (taken when timer==0):
  - ALLRED -> EMERG if emerg.
  - ALLRED -> WALK if ped_pend.
  - ALLRED -> NS_GREEN or EW_GREEN otherwise, chosen by next_dir.
  - NS_GREEN -> NS_YELLOW; EW_GREEN -> EW_YELLOW.
  - Any YELLOW -> ALLRED.
  - WALK -> ALLRED.
- next_dir toggles on entry to either YELLOW, so the two roads alternate.
- ped_pend:
  - Set on any cycle with ped_req=1 while state != WALK.
  - Cleared on entry to WALK; ped_ack pulses on that same edge (registered).
  - A request during WALK is ignored.
- Emergency (priority over pedestrian):
  - emerg=1 in a GREEN: move to that road's YELLOW on the next edge, regardless of timer.
  - emerg=1 in WALK: move to ALLRED on the next edge.
  - emerg=1 in YELLOW or ALLRED: the phase runs to completion, then ALLRED exits to EMERG.
  - EMERG: all heads 100, walk=0. Held while emerg=1. emerg=0 -> ALLRED with a full ALLRED_CYC count, then normal sequencing.
  - ped_pend is preserved through an emergency.
- Simultaneous ped_pend and emerg at ALLRED expiry: EMERG wins.
- Reset mid-phase: immediate return to reset values, whatever the phase.
- Safety invariant: ns_light[0]|ns_light[1] and ew_light[0]|ew_light[1] are never both 1. walk=1 implies both heads are 100.

Test Plan:
- Release reset at cycle 0, no requests (defaults). Required:
  - Cycles 0-1 ALLRED.
  - Cycles 2-9 NS_GREEN (ns=001, ew=100).
  - Cycles 10-12 NS_YELLOW.
  - Cycles 13-14 ALLRED.
  - Cycles 15-22 EW_GREEN.
  - Period 26 cycles, repeating.
- One-cycle ped_req at cycle 5 (NS_GREEN). Required:
  - NS_YELLOW at 10-12, ALLRED at 13-14.
  - WALK at 15-20 with walk=1 and ped_ack=1 only at cycle 15.
  - ALLRED at 21-22, EW_GREEN from 23.
- emerg=1 raised at cycle 4, dropped at cycle 20. Required:
  - NS_YELLOW at 5-7, ALLRED at 8-9.
  - EMERG from 10 through cycle 20.
  - ALLRED at 21-22, EW_GREEN from 23.
- ped_req and emerg both asserted at cycle 4, emerg dropped at 20. Required: EMERG first, then ALLRED 21-22, then WALK 23-28 with ped_ack at 23.
- rst asserted asynchronously mid-WALK (between edges). Required: outputs go to reset values immediately (walk=0, both heads 100, state=0, ped_ack=0), and the cycle-0 sequence restarts on release.
- Parameters all 1 (GREEN/YELLOW/ALLRED/WALK_CYC=1). Required: each phase lasts exactly one cycle, period 6 cycles, no illegal state. The safety invariant is checked by assertion in every test.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer with pedestrian and emergency arbitration.
// Lights, walk lamp and status are decoded from registered state only.
module traffic_phase_ctrl #(
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 6,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ped_req,
    input  logic             emerg,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic             walk,
    output logic             ped_ack,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] timer
);

    typedef enum logic [2:0] {
        ST_ALLRED    = 3'd0,
        ST_NS_GREEN  = 3'd1,
        ST_NS_YELLOW = 3'd2,
        ST_EW_GREEN  = 3'd3,
        ST_EW_YELLOW = 3'd4,
        ST_WALK      = 3'd5,
        ST_EMERG     = 3'd6,
        ST_ILLEGAL   = 3'd7
    } phase_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    phase_t           cur, nxt;
    logic [CNT_W-1:0] timer_q, timer_nx;
    logic             next_dir, next_dir_nx;   // 0: NS goes next, 1: EW goes next
    logic             ped_pend, ped_pend_nx;
    logic             ack_nx;
    logic             expire, entering;

    // Timer reload value (duration minus one) for the phase being entered.
    function automatic logic [CNT_W-1:0] load_val(input phase_t p);
        logic [CNT_W-1:0] v;
        case (p)
            ST_NS_GREEN, ST_EW_GREEN:   v = CNT_W'(GREEN_CYC - 1);
            ST_NS_YELLOW, ST_EW_YELLOW: v = CNT_W'(YELLOW_CYC - 1);
            ST_WALK:                    v = CNT_W'(WALK_CYC - 1);
            ST_EMERG:                   v = '0;
            default:                    v = CNT_W'(ALLRED_CYC - 1);
        endcase
        return v;
    endfunction

    // Next phase: timed exits, with emergency cutting short greens and walk.
    always_comb begin
        nxt    = cur;
        expire = (timer_q == '0);
        case (cur)
            ST_ALLRED: begin
                if (expire) begin
                    if (emerg)         nxt = ST_EMERG;
                    else if (ped_pend) nxt = ST_WALK;
                    else if (next_dir) nxt = ST_EW_GREEN;
                    else               nxt = ST_NS_GREEN;
                end
            end
            ST_NS_GREEN:  if (emerg || expire) nxt = ST_NS_YELLOW;
            ST_EW_GREEN:  if (emerg || expire) nxt = ST_EW_YELLOW;
            ST_NS_YELLOW: if (expire)          nxt = ST_ALLRED;
            ST_EW_YELLOW: if (expire)          nxt = ST_ALLRED;
            ST_WALK:      if (emerg || expire) nxt = ST_ALLRED;
            ST_EMERG:     if (!emerg)          nxt = ST_ALLRED;
            default:                           nxt = ST_ALLRED;
        endcase
    end

    // Side effects of the chosen transition: timer reload, road alternation, pedestrian latch.
    always_comb begin
        entering    = (nxt != cur);
        timer_nx    = timer_q;
        next_dir_nx = next_dir;
        ped_pend_nx = ped_pend;
        ack_nx      = 1'b0;
        if (entering)
            timer_nx = load_val(nxt);
        else if (cur == ST_EMERG)
            timer_nx = '0;
        else
            timer_nx = timer_q - CNT_W'(1);
        if (entering && (nxt == ST_NS_YELLOW || nxt == ST_EW_YELLOW))
            next_dir_nx = ~next_dir;
        if (entering && nxt == ST_WALK) begin
            ped_pend_nx = 1'b0;
            ack_nx      = 1'b1;
        end else if (ped_req && cur != ST_WALK) begin
            ped_pend_nx = 1'b1;
        end
    end

    // Phase, timer and arbitration registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= ST_ALLRED;
            timer_q  <= CNT_W'(ALLRED_CYC - 1);
            next_dir <= 1'b0;
            ped_pend <= 1'b0;
            ped_ack  <= 1'b0;
        end else begin
            cur      <= nxt;
            timer_q  <= timer_nx;
            next_dir <= next_dir_nx;
            ped_pend <= ped_pend_nx;
            ped_ack  <= ack_nx;
        end
    end

    // Head and lamp decode from the registered phase.
    always_comb begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
        walk     = 1'b0;
        case (cur)
            ST_NS_GREEN:  ns_light = LIGHT_GREEN;
            ST_NS_YELLOW: ns_light = LIGHT_YELLOW;
            ST_EW_GREEN:  ew_light = LIGHT_GREEN;
            ST_EW_YELLOW: ew_light = LIGHT_YELLOW;
            ST_WALK:      walk     = 1'b1;
            default:      ;
        endcase
    end

    assign state = cur;
    assign timer = timer_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: planned scenarios plus random requests against a
// phase/elapsed-time reference model; a second instance runs with all durations 1.
module tb_traffic_phase_ctrl;

    localparam int G = 8, Y = 3, A = 2, W = 6;

    logic       clk, rst, ped_req, emerg;
    logic [2:0] ns0, ew0, st0, ns1, ew1, st1;
    logic       walk0, ack0, walk1, ack1;
    logic [7:0] tm0, tm1;

    int ncmp = 0;
    int nerr = 0;

    // model: phase, cycles elapsed in phase, next road, pending request, ack pulse
    int m_ph, m_el, m_nd, m_pend, m_ack;
    int DUR[7] = '{A, G, Y, G, Y, W, 0};

    traffic_phase_ctrl #(.GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(A), .WALK_CYC(W), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .ped_req(ped_req), .emerg(emerg),
        .ns_light(ns0), .ew_light(ew0), .walk(walk0), .ped_ack(ack0),
        .state(st0), .timer(tm0)
    );

    traffic_phase_ctrl #(.GREEN_CYC(1), .YELLOW_CYC(1), .ALLRED_CYC(1), .WALK_CYC(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .ped_req(ped_req), .emerg(emerg),
        .ns_light(ns1), .ew_light(ew1), .walk(walk1), .ped_ack(ack1),
        .state(st1), .timer(tm1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, act, exp);
        end
    endtask

    function automatic int light_code(input int ph, input int grn, input int yel);
        if (ph == grn) return 1;
        if (ph == yel) return 2;
        return 4;
    endfunction

    function automatic int safe(input logic [2:0] ns, input logic [2:0] ew, input logic wk);
        bit conflict, walk_bad;
        conflict = (ns[0] | ns[1]) && (ew[0] | ew[1]);
        walk_bad = wk && !(ns == 3'b100 && ew == 3'b100);
        return (!conflict && !walk_bad) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_el = 0; m_nd = 0; m_pend = 0; m_ack = 0;
    endtask

    task automatic model_step(input bit p, input bit e);
        int nx;
        bit done;
        nx   = m_ph;
        done = (m_ph != 6) && (m_el == DUR[m_ph] - 1);
        case (m_ph)
            0: if (done) nx = e ? 6 : (m_pend != 0) ? 5 : (m_nd != 0) ? 3 : 1;
            1: if (e || done) nx = 2;
            3: if (e || done) nx = 4;
            2, 4: if (done) nx = 0;
            5: if (e || done) nx = 0;
            6: if (!e) nx = 0;
            default: nx = 0;
        endcase
        m_ack = (nx == 5 && m_ph != 5) ? 1 : 0;
        if (m_ack != 0) m_pend = 0;
        else if (p && m_ph != 5) m_pend = 1;
        if (nx != m_ph && (nx == 2 || nx == 4)) m_nd ^= 1;
        m_el = (nx != m_ph) ? 0 : m_el + 1;
        m_ph = nx;
    endtask

    task automatic compare_all();
        chk("state", st0, m_ph);
        chk("timer", tm0, (m_ph == 6) ? 0 : DUR[m_ph] - 1 - m_el);
        chk("ns_light", ns0, light_code(m_ph, 1, 2));
        chk("ew_light", ew0, light_code(m_ph, 3, 4));
        chk("walk", walk0, (m_ph == 5) ? 1 : 0);
        chk("ped_ack", ack0, m_ack);
        chk("safety0", safe(ns0, ew0, walk0), 1);
        chk("safety1", safe(ns1, ew1, walk1), 1);
        chk("legal1", (st1 == 3'd7) ? 1 : 0, 0);
    endtask

    // Phase required by the written test plan for scenario scn at cycle c (-1: not stated)
    function automatic int plan_state(input int scn, input int c);
        int k;
        if (scn == 1) begin
            k = c % 26;
            if (k <= 1)  return 0;
            if (k <= 9)  return 1;
            if (k <= 12) return 2;
            if (k <= 14) return 0;
            if (k <= 22) return 3;
            if (k <= 25) return 4;
            return -1;
        end
        if (scn == 2) begin
            if (c <= 1)  return 0;
            if (c <= 9)  return 1;
            if (c <= 12) return 2;
            if (c <= 14) return 0;
            if (c <= 20) return 5;
            if (c <= 22) return 0;
            if (c <= 30) return 3;
            return -1;
        end
        if (c <= 1)  return 0;
        if (c <= 4)  return 1;
        if (c <= 7)  return 2;
        if (c <= 9)  return 0;
        if (c <= 20) return 6;
        if (c <= 22) return 0;
        if (scn == 3) return (c <= 30) ? 3 : -1;
        if (c <= 28) return 5;
        if (c <= 30) return 0;
        return (c == 31) ? 3 : -1;
    endfunction

    task automatic reset_seq();
        rst = 1'b1; ped_req = 1'b0; emerg = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs ncyc cycles of a planned scenario; returns at the negedge of cycle ncyc, unchecked.
    task automatic run_scn(input int scn, input int ncyc);
        int pat[6] = '{0, 1, 2, 0, 3, 4};
        int e;
        bit p, em;
        for (int c = 0; c < ncyc; c++) begin
            compare_all();
            e = plan_state(scn, c);
            if (e >= 0) chk("plan_state", st0, e);
            if (scn == 2) chk("plan_ack", ack0, (c == 15) ? 1 : 0);
            if (scn == 4) chk("plan_ack", ack0, (c == 23) ? 1 : 0);
            if (scn == 1) begin
                chk("p1_state", st1, pat[c % 6]);
                chk("p1_timer", tm1, 0);
            end
            p  = (scn == 2 && c == 5) || (scn == 4 && c == 4);
            em = (scn == 3 || scn == 4) && c >= 4 && c < 20;
            ped_req = p;
            emerg   = em;
            model_step(p, em);
            @(negedge clk);
        end
    endtask

    initial begin
        bit p, em;
        rst = 1'b1; ped_req = 1'b0; emerg = 1'b0;
        model_reset();
        @(negedge clk);

        reset_seq();
        chk("rst_state", st0, 0);
        chk("rst_timer", tm0, A - 1);
        chk("rst_ns", ns0, 4);
        chk("rst_ew", ew0, 4);
        run_scn(1, 60);

        reset_seq(); run_scn(2, 31);
        reset_seq(); run_scn(3, 31);
        reset_seq(); run_scn(4, 32);

        // asynchronous reset in the first WALK cycle, between clock edges
        reset_seq(); run_scn(2, 15);
        chk("pre_rst_state", st0, 5);
        chk("pre_rst_walk", walk0, 1);
        chk("pre_rst_ack", ack0, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_state", st0, 0);
        chk("async_walk", walk0, 0);
        chk("async_ack", ack0, 0);
        chk("async_ns", ns0, 4);
        chk("async_ew", ew0, 4);
        chk("async_timer", tm0, A - 1);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        run_scn(1, 30);

        // random requests, emergency bursts and occasional resets
        reset_seq();
        em = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            compare_all();
            if (rst) begin
                rst = 1'b0;
                p  = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 39) == 0) em = ~em;
                ped_req = p; emerg = em;
                model_step(p, em);
            end else if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                p  = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 39) == 0) em = ~em;
                ped_req = p; emerg = em;
                model_step(p, em);
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
